gpr_file_sb: RTL and testbench
==============================

Name: gpr_file_sb

Overview:
Parametrised general-purpose register file for the multi-cycle MIPS core. It is the successor to the fixed 32x32 GPR. It adds configurable width and depth, parameterised reset values for $gp and $sp, and an overflow-flag register whose index is configurable. It also adds a per-register busy scoreboard, so multi-cycle producers can reserve a destination and the control unit can stall dependent reads. It sits between decode (rs/rt reads), the write-back mux (busW), and the control FSM (reservation and stall).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
GP_IDX, 28, index of $gp
GP_INIT, 32'h0000_1800, reset value of $gp
SP_IDX, 29, index of $sp
SP_INIT, 32'h0000_2ffc, reset value of $sp
OV_IDX, 30, index of overflow-flag register; bit 0 is the flag

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
rs  in  ADDR_W  read address A
rt  in  ADDR_W  read address B
busA  out  DATA_W  Regs[rs], combinational
busB  out  DATA_W  Regs[rt], combinational
reg_wr  in  1  write-back strobe
rd  in  ADDR_W  write address
busW  in  DATA_W  write data
ov  in  1  ALU overflow for the current write-back
mark_busy  in  1  reserve destination busy_addr
busy_addr  in  ADDR_W  register to reserve
busy_a  out  1  busy[rs]
busy_b  out  1  busy[rt]
ov_flag  out  1  Regs[OV_IDX][0]
busy_cnt  out  ADDR_W+1  number of registers currently busy

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All registers are 0, except Regs[GP_IDX]=GP_INIT and Regs[SP_IDX]=SP_INIT.
  - All busy bits are 0, so busy_cnt=0 and ov_flag=0.
  - Reset asserted mid-operation discards any pending reservations immediately. No write occurs on the release edge.
- Register 0:
  - Always reads 0.
  - Writes to it are ignored.
  - It can never be marked busy; mark_busy with busy_addr=0 is a no-op.
- Reads: busA and busB are combinational from the array, with zero added latency. A value written at edge N is visible after edge N.
- Write with reg_wr=1, ov=0:
  - Regs[rd] <= busW, when rd!=0.
  - Regs[OV_IDX][0] <= 0 and the other OV_IDX bits are unchanged, unless rd==OV_IDX, in which case busW is written whole.
- Write with reg_wr=1, ov=1:
  - Regs[rd] is unchanged.
  - Regs[OV_IDX][0] <= 1 and the other bits are preserved.
- reg_wr=0: no register change; the flag holds.
- Scoreboard:
  - mark_busy sets busy[busy_addr].
  - reg_wr clears busy[rd], regardless of ov.
  - Same-edge mark and clear of the same address: set wins, because a new producer reserves the register.
  - Mark and clear of different addresses on the same edge: both take effect.
  - Re-marking an already-busy register leaves the count unchanged.
- busy_cnt is a registered count of set busy bits.
  - Updated on the same edge as the busy vector, including the net effect of simultaneous set/clear (+1, -1 or 0).
  - Range 0..2**ADDR_W-1; it cannot overflow because reg 0 is excluded.
- Clearing a non-busy register leaves busy_cnt unchanged, with no underflow.
- Parameter rules:
  - GP_IDX, SP_IDX and OV_IDX are distinct, nonzero and < 2**ADDR_W.
  - Init values are truncated or zero-extended to DATA_W.

Optional Feature:
Macro GPR_BYPASS_EN.
- Defined: when reg_wr=1, ov=0, rd!=0 and rd==rs, busA=busW in the same cycle and busy_a=0. The same applies for rt, busB and busy_b. When rs==OV_IDX and the write clears or sets the flag, busA is not bypassed for the flag-only update.
- Undefined: reads return the array contents, and busy_a/busy_b reflect the pre-edge busy vector.

Test Plan:
- Reset: pulse reset_n low mid-cycle -> read all 32 regs: R28=0x1800, R29=0x2ffc, others 0; busy_cnt=0, ov_flag=0.
- Write R0: reg_wr, rd=0, busW=0xDEADBEEF, then rs=0 -> busA=0; mark_busy busy_addr=0 -> busy_cnt stays 0.
- Overflow: R30=0xF0, write rd=5 busW=7 ov=1 -> R5 unchanged, R30=0xF1, ov_flag=1; next write rd=5 busW=7 ov=0 -> R5=7, R30=0xF0.
- Scoreboard: mark R8, then R9 -> busy_cnt=2, busy_a=1 with rs=8; reg_wr rd=8 together with mark_busy busy_addr=8 -> busy[8] stays 1, busy_cnt=2; reg_wr rd=9 -> busy_cnt=1.
- Simultaneous: mark R3 and reg_wr rd=4 (R4 busy) on the same edge -> busy_cnt unchanged, busy[3]=1, busy[4]=0.
- Bypass (GPR_BYPASS_EN): R7 busy, reg_wr rd=7 busW=0x1234, rs=7 -> busA=0x1234 and busy_a=0 in the same cycle; without the macro -> old value and busy_a=1 until the edge.

Source files
------------

// File: rtl/gpr_file_sb_if.sv
// Bus bundle for gpr_file_sb: decode reads, write-back port and busy reservation.
// The master drives addresses/strobes; the slave (register file) returns data, busy bits and the count.
interface gpr_file_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] rs;
   logic [ADDR_W-1:0] rt;
   logic [DATA_W-1:0] busA;
   logic [DATA_W-1:0] busB;
   logic              reg_wr;
   logic [ADDR_W-1:0] rd;
   logic [DATA_W-1:0] busW;
   logic              ov;
   logic              mark_busy;
   logic [ADDR_W-1:0] busy_addr;
   logic              busy_a;
   logic              busy_b;
   logic              ov_flag;
   logic [ADDR_W:0]   busy_cnt;

   // Strobes (reg_wr, mark_busy) are single-cycle qualifiers sampled on the rising clock edge;
   // there is no backpressure, every strobe present at an edge takes effect at that edge.
   modport master (
      output rs, rt, reg_wr, rd, busW, ov, mark_busy, busy_addr,
      input  busA, busB, busy_a, busy_b, ov_flag, busy_cnt
   );

   modport slave (
      input  rs, rt, reg_wr, rd, busW, ov, mark_busy, busy_addr,
      output busA, busB, busy_a, busy_b, ov_flag, busy_cnt
   );
endinterface

// File: rtl/gpr_file_sb.sv
// Parametrised MIPS GPR file with overflow-flag register and per-register busy scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining GPR_BYPASS_EN.
module gpr_file_sb #(
   parameter int          DATA_W  = 32,
   parameter int          ADDR_W  = 5,
   parameter int          GP_IDX  = 28,
   parameter logic [31:0] GP_INIT = 32'h0000_1800,
   parameter int          SP_IDX  = 29,
   parameter logic [31:0] SP_INIT = 32'h0000_2ffc,
   parameter int          OV_IDX  = 30
) (
   input  logic         clk,
   input  logic         reset_n,
   gpr_file_sb_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] OV_A = ADDR_W'(OV_IDX);

   function automatic logic [DATA_W-1:0] f_reset_val(input int idx);
      if (idx == GP_IDX)      return DATA_W'(GP_INIT);
      else if (idx == SP_IDX) return DATA_W'(SP_INIT);
      else                    return '0;
   endfunction

   logic [DATA_W-1:0] r_regs [DEPTH];
   logic [DEPTH-1:0]  r_busy;
   logic [ADDR_W:0]   r_busy_cnt;

   logic              w_wr_data;
   logic              w_set;
   logic              w_inc;
   logic              w_dec;
   logic [DEPTH-1:0]  w_busy_nxt;
   logic [DATA_W-1:0] w_rd_a;
   logic [DATA_W-1:0] w_rd_b;
   logic              w_busy_a;
   logic              w_busy_b;

   assign w_wr_data = bus.reg_wr && !bus.ov && (bus.rd != '0);

   // An overflowing write only raises the flag; any other write clears it unless it targets the flag register itself.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_regs[i] <= f_reset_val(i);
         end
      end else if (bus.reg_wr) begin
         if (w_wr_data) begin
            r_regs[bus.rd] <= bus.busW;
         end
         if (bus.ov) begin
            r_regs[OV_A][0] <= 1'b1;
         end else if (bus.rd != OV_A) begin
            r_regs[OV_A][0] <= 1'b0;
         end
      end
   end

   assign w_set = bus.mark_busy && (bus.busy_addr != '0);

   // Clear first, then set, so a new reservation wins over a same-edge retirement.
   always_comb begin
      w_busy_nxt = r_busy;
      if (bus.reg_wr) begin
         w_busy_nxt[bus.rd] = 1'b0;
      end
      if (w_set) begin
         w_busy_nxt[bus.busy_addr] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   assign w_inc = w_set && !r_busy[bus.busy_addr];
   assign w_dec = bus.reg_wr && r_busy[bus.rd] && !(w_set && (bus.busy_addr == bus.rd));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_busy     <= '0;
         r_busy_cnt <= '0;
      end else begin
         r_busy     <= w_busy_nxt;
         r_busy_cnt <= r_busy_cnt + (ADDR_W+1)'(w_inc) - (ADDR_W+1)'(w_dec);
      end
   end

   always_comb begin
      w_rd_a   = (bus.rs == '0) ? '0 : r_regs[bus.rs];
      w_rd_b   = (bus.rt == '0) ? '0 : r_regs[bus.rt];
      w_busy_a = r_busy[bus.rs];
      w_busy_b = r_busy[bus.rt];
`ifdef GPR_BYPASS_EN
      if (w_wr_data && (bus.rd == bus.rs)) begin
         w_rd_a   = bus.busW;
         w_busy_a = 1'b0;
      end
      if (w_wr_data && (bus.rd == bus.rt)) begin
         w_rd_b   = bus.busW;
         w_busy_b = 1'b0;
      end
`else
`endif
   end

   assign bus.busA     = w_rd_a;
   assign bus.busB     = w_rd_b;
   assign bus.busy_a   = w_busy_a;
   assign bus.busy_b   = w_busy_b;
   assign bus.ov_flag  = r_regs[OV_A][0];
   assign bus.busy_cnt = r_busy_cnt;
endmodule

// File: tb/tb_gpr_file_sb.sv
// Self-checking bench for gpr_file_sb: directed vector table, hand-written corner sequences
// and randomized traffic against a behavioural model of the register file and scoreboard.
module tb_gpr_file_sb;
   logic clk = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   gpr_file_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   gpr_file_sb dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   typedef struct {
      string       name;
      logic        wr;
      logic [4:0]  rd;
      logic [31:0] w;
      logic        ov;
      logic        mk;
      logic [4:0]  ma;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [31:0] ea;
      logic [31:0] eb;
      logic        eba;
      logic        ebb;
      logic        eov;
      logic [5:0]  ecnt;
   } vec_t;

   vec_t        vecs [$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] m_regs [32];
   bit          m_busy [32];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      bus.reg_wr    = 1'b0;
      bus.rd        = '0;
      bus.busW      = '0;
      bus.ov        = 1'b0;
      bus.mark_busy = 1'b0;
      bus.busy_addr = '0;
   endtask

   task automatic m_reset();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      m_regs[28] = 32'h0000_1800;
      m_regs[29] = 32'h0000_2ffc;
   endtask

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
      return c;
   endfunction

   function automatic logic [4:0] rnd_addr();
      if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
      return 5'($urandom_range(0, 31));
   endfunction

   task automatic run_vec(input vec_t v);
      @(negedge clk);
      bus.reg_wr = v.wr; bus.rd = v.rd; bus.busW = v.w; bus.ov = v.ov;
      bus.mark_busy = v.mk; bus.busy_addr = v.ma; bus.rs = v.rs; bus.rt = v.rt;
      @(posedge clk);
      #1 idle();
      #1;
      chk({v.name, ".busA"}, bus.busA, v.ea);
      chk({v.name, ".busB"}, bus.busB, v.eb);
      chk({v.name, ".busy_a"}, 32'(bus.busy_a), 32'(v.eba));
      chk({v.name, ".busy_b"}, 32'(bus.busy_b), 32'(v.ebb));
      chk({v.name, ".ov_flag"}, 32'(bus.ov_flag), 32'(v.eov));
      chk({v.name, ".busy_cnt"}, 32'(bus.busy_cnt), 32'(v.ecnt));
   endtask

   initial begin
      logic [4:0]  r_rs, r_rt, r_rd, r_ma;
      logic [31:0] r_w, exp_a, exp_b;
      logic        r_wr, r_ov, r_mk, exp_ba, exp_bb;

      idle();
      bus.rs = 5'd28;
      bus.rt = 5'd29;
      #12;
      chk("reset.busy_cnt", 32'(bus.busy_cnt), 32'd0);
      chk("reset.ov_flag", 32'(bus.ov_flag), 32'd0);
      chk("reset.gp", bus.busA, 32'h0000_1800);
      chk("reset.sp", bus.busB, 32'h0000_2ffc);
      @(negedge clk) reset_n = 1'b1;

      //                name            wr  rd     w              ov  mk  ma     rs     rt     ea             eb             eba ebb eov cnt
      vecs.push_back('{"wr_r0",        1, 5'd0,  32'hDEADBEEF, 0,  0, 5'd0,  5'd0,  5'd28, 32'h0,         32'h1800,      0,  0,  0,  6'd0});
      vecs.push_back('{"mark_r0",      0, 5'd0,  32'h0,        0,  1, 5'd0,  5'd0,  5'd29, 32'h0,         32'h2ffc,      0,  0,  0,  6'd0});
      vecs.push_back('{"wr_r30",       1, 5'd30, 32'hF0,       0,  0, 5'd0,  5'd30, 5'd0,  32'hF0,        32'h0,         0,  0,  0,  6'd0});
      vecs.push_back('{"ov_set",       1, 5'd5,  32'h7,        1,  0, 5'd0,  5'd5,  5'd30, 32'h0,         32'hF1,        0,  0,  1,  6'd0});
      vecs.push_back('{"ov_clr",       1, 5'd5,  32'h7,        0,  0, 5'd0,  5'd5,  5'd30, 32'h7,         32'hF0,        0,  0,  0,  6'd0});
      vecs.push_back('{"mark_r8",      0, 5'd0,  32'h0,        0,  1, 5'd8,  5'd8,  5'd9,  32'h0,         32'h0,         1,  0,  0,  6'd1});
      vecs.push_back('{"mark_r9",      0, 5'd0,  32'h0,        0,  1, 5'd9,  5'd8,  5'd9,  32'h0,         32'h0,         1,  1,  0,  6'd2});
      vecs.push_back('{"remark_r9",    0, 5'd0,  32'h0,        0,  1, 5'd9,  5'd9,  5'd8,  32'h0,         32'h0,         1,  1,  0,  6'd2});
      vecs.push_back('{"clr_set_r8",   1, 5'd8,  32'h88,       0,  1, 5'd8,  5'd8,  5'd9,  32'h88,        32'h0,         1,  1,  0,  6'd2});
      vecs.push_back('{"clr_r9",       1, 5'd9,  32'h99,       0,  0, 5'd0,  5'd9,  5'd8,  32'h99,        32'h88,        0,  1,  0,  6'd1});
      vecs.push_back('{"mark_r4",      0, 5'd0,  32'h0,        0,  1, 5'd4,  5'd4,  5'd3,  32'h0,         32'h0,         1,  0,  0,  6'd2});
      vecs.push_back('{"mark3_clr4",   1, 5'd4,  32'h44,       0,  1, 5'd3,  5'd3,  5'd4,  32'h0,         32'h44,        1,  0,  0,  6'd2});
      vecs.push_back('{"clr_idle_ov",  1, 5'd10, 32'hA,        1,  0, 5'd0,  5'd10, 5'd30, 32'h0,         32'hF1,        0,  0,  1,  6'd2});
      vecs.push_back('{"clr_busy_ov",  1, 5'd3,  32'h33,       1,  0, 5'd0,  5'd3,  5'd8,  32'h0,         32'h88,        0,  1,  1,  6'd1});
      vecs.push_back('{"wr_ov_whole",  1, 5'd30, 32'hAB,       0,  0, 5'd0,  5'd30, 5'd0,  32'hAB,        32'h0,         0,  0,  1,  6'd1});
      vecs.push_back('{"no_write",     0, 5'd0,  32'h0,        0,  0, 5'd0,  5'd28, 5'd29, 32'h1800,      32'h2ffc,      0,  0,  1,  6'd1});
      vecs.push_back('{"clr_r8",       1, 5'd8,  32'h8,        0,  0, 5'd0,  5'd8,  5'd30, 32'h8,         32'hAA,        0,  0,  0,  6'd0});

      foreach (vecs[i]) run_vec(vecs[i]);

      // Busy destination being written while it is read in the same cycle.
      @(negedge clk);
      bus.mark_busy = 1'b1; bus.busy_addr = 5'd7;
      @(posedge clk);
      #1 idle();
      @(negedge clk);
      bus.reg_wr = 1'b1; bus.rd = 5'd7; bus.busW = 32'h1234; bus.rs = 5'd7; bus.rt = 5'd0;
      #1;
`ifdef GPR_BYPASS_EN
      chk("bypass.busA", bus.busA, 32'h1234);
      chk("bypass.busy_a", 32'(bus.busy_a), 32'd0);
`else
      chk("nobypass.busA", bus.busA, 32'h0);
      chk("nobypass.busy_a", 32'(bus.busy_a), 32'd1);
`endif
      @(posedge clk);
      #1 idle();
      #1;
      chk("after_wr7.busA", bus.busA, 32'h1234);
      chk("after_wr7.busy_a", 32'(bus.busy_a), 32'd0);
      chk("after_wr7.busy_cnt", 32'(bus.busy_cnt), 32'd0);

      // Reset in the middle of a cycle with a reservation and the flag pending.
      @(negedge clk);
      bus.mark_busy = 1'b1; bus.busy_addr = 5'd6;
      bus.reg_wr = 1'b1; bus.rd = 5'd11; bus.busW = 32'h5555; bus.ov = 1'b1;
      @(posedge clk);
      #1 idle();
      #1;
      chk("pre_reset.busy_cnt", 32'(bus.busy_cnt), 32'd1);
      chk("pre_reset.ov_flag", 32'(bus.ov_flag), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("async_reset.busy_cnt", 32'(bus.busy_cnt), 32'd0);
      chk("async_reset.ov_flag", 32'(bus.ov_flag), 32'd0);
      @(negedge clk) reset_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         bus.rs = 5'(i);
         bus.rt = 5'(31 - i);
         #1;
         exp_a = (i == 28) ? 32'h1800 : (i == 29) ? 32'h2ffc : 32'h0;
         chk($sformatf("sweep.R%0d", i), bus.busA, exp_a);
         chk($sformatf("sweep.busy%0d", i), 32'(bus.busy_a), 32'd0);
      end

      m_reset();
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         r_wr = ($urandom_range(0, 2) != 0);
         r_rd = rnd_addr();
         r_w  = $urandom;
         r_ov = ($urandom_range(0, 3) == 0);
         r_mk = ($urandom_range(0, 1) == 0);
         r_ma = rnd_addr();
         r_rs = (r_wr && $urandom_range(0, 3) == 0) ? r_rd : rnd_addr();
         r_rt = rnd_addr();
         bus.reg_wr = r_wr; bus.rd = r_rd; bus.busW = r_w; bus.ov = r_ov;
         bus.mark_busy = r_mk; bus.busy_addr = r_ma; bus.rs = r_rs; bus.rt = r_rt;
         #1;
         exp_a  = (r_rs == 0) ? 32'h0 : m_regs[r_rs];
         exp_b  = (r_rt == 0) ? 32'h0 : m_regs[r_rt];
         exp_ba = m_busy[r_rs];
         exp_bb = m_busy[r_rt];
`ifdef GPR_BYPASS_EN
         if (r_wr && !r_ov && r_rd != 0 && r_rd == r_rs) begin exp_a = r_w; exp_ba = 1'b0; end
         if (r_wr && !r_ov && r_rd != 0 && r_rd == r_rt) begin exp_b = r_w; exp_bb = 1'b0; end
`endif
         chk("rand.busA", bus.busA, exp_a);
         chk("rand.busB", bus.busB, exp_b);
         chk("rand.busy_a", 32'(bus.busy_a), 32'(exp_ba));
         chk("rand.busy_b", 32'(bus.busy_b), 32'(exp_bb));
         chk("rand.ov_flag", 32'(bus.ov_flag), 32'(m_regs[30][0]));
         chk("rand.busy_cnt", 32'(bus.busy_cnt), 32'(m_count()));
         @(posedge clk);
         if (r_wr) begin
            if (r_ov) m_regs[30][0] = 1'b1;
            else begin
               if (r_rd != 0) m_regs[r_rd] = r_w;
               if (r_rd != 30) m_regs[30][0] = 1'b0;
            end
            m_busy[r_rd] = 1'b0;
         end
         if (r_mk && r_ma != 0) m_busy[r_ma] = 1'b1;
      end
      @(negedge clk) idle();
      #1;
      chk("final.ov_flag", 32'(bus.ov_flag), 32'(m_regs[30][0]));
      chk("final.busy_cnt", 32'(bus.busy_cnt), 32'(m_count()));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
